// File: rtl/decode_stage.sv
// Buffered RV32I decode stage: FIFO of fetched (instr, pc) pairs, combinational decode of the head,
// valid/ready output register. Define RV_M_EXT_EN to decode the M-extension (MUL/DIV/REM) ops.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_PASS_B,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [1:0] {
        MEM_WORD = 2'd0,
        MEM_BYTE = 2'd1,
        MEM_HALF = 2'd2
    } mem_op_e;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;      // operand B is the immediate
        logic       alu_a_pc;     // operand A is the PC (AUIPC, JAL)
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       mem_unsigned;
        logic       branch;
        logic       jump;
        logic [2:0] branch_op;
        alu_op_e    alu_op;
        mem_op_e    mem_op;
    } ctrl_signals_t;

    localparam ctrl_signals_t CTRL_DEFAULT = '0;

endpackage

module decode_stage
    import riscv_pkg::*;
#(
    parameter int  XLEN       = riscv_pkg::XLEN,
    parameter int  FIFO_DEPTH = 4,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_instr,
    input  logic [XLEN-1:0]     in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_instr,
    output logic [XLEN-1:0]     out_pc,
    output ctrl_signals_t       out_ctrl,
    output logic                out_illegal,
    output logic                out_is_ecall,
    output logic                out_is_ebreak,
    output logic                out_is_csr,
    output logic [2:0]          out_csr_op,
    output logic [CNT_W-1:0]    occupancy
);

    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        ctrl_signals_t   ctrl;
        logic            illegal;
        logic            is_ecall;
        logic            is_ebreak;
        logic            is_csr;
        logic [2:0]      csr_op;
    } out_entry_t;

    logic [XLEN-1:0]  instr_mem [FIFO_DEPTH];
    logic [XLEN-1:0]  pc_mem    [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    out_entry_t       out_q, out_d, dec;
    logic             push, load;

    assign in_ready = !rst && !flush && (count_q < FULL_CNT);
    assign push     = in_valid && in_ready;
    assign load     = !flush && (count_q != '0) && (!out_valid_q || out_ready);

    // NOTE: the buffer array has no reset; only slots covered by count_q are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= in_instr;
            pc_mem[wr_ptr_q]    <= in_pc;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (load) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, load})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    function automatic alu_op_e base_alu(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic mem_op_e mem_width(input logic [1:0] sz);
        case (sz)
            2'b00:   return MEM_BYTE;
            2'b01:   return MEM_HALF;
            default: return MEM_WORD;
        endcase
    endfunction

    logic [31:0] hi;
    logic [2:0]  f3;
    logic [6:0]  f7;

    assign hi = instr_mem[rd_ptr_q];
    assign f3 = hi[14:12];
    assign f7 = hi[31:25];

    always_comb begin
        // NOTE: every field is defaulted before the case so no path can infer a latch.
        dec       = '0;
        dec.instr = hi;
        dec.pc    = pc_mem[rd_ptr_q];
        case (hi[6:0])
            OPC_LUI: begin
                dec.ctrl.reg_write = 1'b1;
                dec.ctrl.alu_src   = 1'b1;
                dec.ctrl.alu_op    = ALU_PASS_B;
            end
            OPC_AUIPC: begin
                dec.ctrl.reg_write = 1'b1;
                dec.ctrl.alu_src   = 1'b1;
                dec.ctrl.alu_a_pc  = 1'b1;
            end
            OPC_JAL: begin
                dec.ctrl.reg_write = 1'b1;
                dec.ctrl.alu_src   = 1'b1;
                dec.ctrl.alu_a_pc  = 1'b1;
                dec.ctrl.jump      = 1'b1;
            end
            OPC_JALR: begin
                dec.illegal        = (f3 != 3'b000);
                dec.ctrl.reg_write = 1'b1;
                dec.ctrl.alu_src   = 1'b1;
                dec.ctrl.jump      = 1'b1;
            end
            OPC_BRANCH: begin
                dec.illegal        = (f3 == 3'b010) || (f3 == 3'b011);
                dec.ctrl.branch    = 1'b1;
                dec.ctrl.branch_op = f3;
                dec.ctrl.alu_op    = ALU_SUB;
            end
            OPC_LOAD: begin
                dec.illegal           = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                dec.ctrl.reg_write    = 1'b1;
                dec.ctrl.alu_src      = 1'b1;
                dec.ctrl.mem_read     = 1'b1;
                dec.ctrl.mem_to_reg   = 1'b1;
                dec.ctrl.mem_unsigned = f3[2];
                dec.ctrl.mem_op       = mem_width(f3[1:0]);
            end
            OPC_STORE: begin
                dec.illegal         = (f3 > 3'b010);
                dec.ctrl.alu_src    = 1'b1;
                dec.ctrl.mem_write  = 1'b1;
                dec.ctrl.mem_op     = mem_width(f3[1:0]);
            end
            OPC_OP_IMM: begin
                if (f3 == 3'b001) dec.illegal = (f7 != 7'b0000000);
                if (f3 == 3'b101) dec.illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                dec.ctrl.reg_write = 1'b1;
                dec.ctrl.alu_src   = 1'b1;
                dec.ctrl.alu_op    = base_alu(f3, (f3 == 3'b101) && f7[5]);
            end
            OPC_OP: begin
                dec.ctrl.reg_write = 1'b1;
                case (f7)
                    7'b0000000: dec.ctrl.alu_op = base_alu(f3, 1'b0);
                    7'b0100000: begin
                        dec.illegal     = (f3 != 3'b000) && (f3 != 3'b101);
                        dec.ctrl.alu_op = base_alu(f3, 1'b1);
                    end
`ifdef RV_M_EXT_EN
                    // ALU_MUL..ALU_REMU are contiguous in funct3 order
                    7'b0000001: dec.ctrl.alu_op = alu_op_e'(5'(ALU_MUL) + 5'(f3));
`else
                    7'b0000001: dec.illegal = 1'b1;
`endif
                    default:    dec.illegal = 1'b1;
                endcase
            end
            OPC_MISC_MEM: ;
            OPC_SYSTEM: begin
                if (f3 == 3'b000) begin
                    if (hi[31:7] == 25'h0)         dec.is_ecall  = 1'b1;
                    else if (hi[31:7] == 25'h2000) dec.is_ebreak = 1'b1;
                    else                           dec.illegal   = 1'b1;
                end else if (f3 == 3'b100) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.is_csr         = 1'b1;
                    dec.csr_op         = f3;
                    dec.ctrl.reg_write = (hi[11:7] != 5'd0);
                    dec.ctrl.alu_op    = ALU_PASS_B;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        if (hi[1:0] != 2'b11) dec.illegal = 1'b1;
        if (dec.illegal) begin
            dec.ctrl      = CTRL_DEFAULT;
            dec.is_ecall  = 1'b0;
            dec.is_ebreak = 1'b0;
            dec.is_csr    = 1'b0;
            dec.csr_op    = 3'b000;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
            out_d       = dec;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_instr     = out_q.instr;
    assign out_pc        = out_q.pc;
    assign out_ctrl      = out_q.ctrl;
    assign out_illegal   = out_q.illegal;
    assign out_is_ecall  = out_q.is_ecall;
    assign out_is_ebreak = out_q.is_ebreak;
    assign out_is_csr    = out_q.is_csr;
    assign out_csr_op    = out_q.csr_op;
    assign occupancy     = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected entries queued at drive time, popped on output handshake.
module tb_decode_stage;
    import riscv_pkg::*;

    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int BUDGET = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_instr = '0;
    logic [31:0]   in_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instr, out_pc;
    ctrl_signals_t out_ctrl;
    logic          out_illegal, out_is_ecall, out_is_ebreak, out_is_csr;
    logic [2:0]    out_csr_op;
    logic [CW-1:0] occupancy;

    decode_stage #(.XLEN(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_ctrl(out_ctrl), .out_illegal(out_illegal), .out_is_ecall(out_is_ecall),
        .out_is_ebreak(out_is_ebreak), .out_is_csr(out_is_csr), .out_csr_op(out_csr_op),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   instr;
        logic [31:0]   pc;
        ctrl_signals_t ctrl;
        logic          illegal;
        logic          ecall;
        logic          ebreak;
        logic          csr;
        logic [2:0]    csr_op;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic ctrl_signals_t ctl(input logic rw, imm, apc, mr, mw, m2r, mu, br, jp,
                                          input logic [2:0] bop, input alu_op_e op,
                                          input mem_op_e mo);
        ctrl_signals_t c;
        c.reg_write = rw;  c.alu_src = imm;  c.alu_a_pc = apc;
        c.mem_read = mr;   c.mem_write = mw; c.mem_to_reg = m2r; c.mem_unsigned = mu;
        c.branch = br;     c.jump = jp;      c.branch_op = bop;
        c.alu_op = op;     c.mem_op = mo;
        return c;
    endfunction

    function automatic exp_t mk(input logic [31:0] instr, pc, input ctrl_signals_t c,
                                input logic il, ec, eb, cs, input logic [2:0] cop);
        exp_t e;
        e.instr = instr; e.pc = pc; e.ctrl = c;
        e.illegal = il; e.ecall = ec; e.ebreak = eb; e.csr = cs; e.csr_op = cop;
        return e;
    endfunction

    localparam ctrl_signals_t C_DEF = '0;
    ctrl_signals_t c_addi;

    function automatic exp_t ill(input logic [31:0] instr, pc);
        return mk(instr, pc, C_DEF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    endfunction

    function automatic exp_t ord(input logic [31:0] instr, pc, input ctrl_signals_t c);
        return mk(instr, pc, c, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    endfunction

    // Present one instruction until accepted; returns #1 after the accepting edge.
    task automatic send(input exp_t e);
        int w = 0;
        sb.push_back(e);
        in_valid = 1'b1;
        in_instr = e.instr;
        in_pc    = e.pc;
        while (in_ready !== 1'b1 && w < BUDGET) begin
            @(posedge clk); #1; w++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL send_timeout instr=%h in_ready=%b required 1", e.instr, in_ready);
            void'(sb.pop_back());
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Pop and compare n outputs; out_ready must already be high.
    task automatic collect(input int n, output int first_wait, output int total);
        exp_t e;
        int   w;
        first_wait = 0;
        total      = 0;
        for (int i = 0; i < n; i++) begin
            w = 0;
            do begin @(negedge clk); w++; total++; end
            while (out_valid !== 1'b1 && w < BUDGET);
            if (out_valid !== 1'b1) begin
                n_checks++;
                $display("FAIL collect_timeout item=%0d out_valid=%b required 1", i, out_valid);
                return;
            end
            if (i == 0) first_wait = w;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow item=%0d got instr=%h required none", i, out_instr);
                return;
            end
            e = sb.pop_front();
            n_checks++;
            if ({out_instr, out_pc} !== {e.instr, e.pc})
                $display("FAIL payload item=%0d got instr=%h pc=%h required instr=%h pc=%h",
                         i, out_instr, out_pc, e.instr, e.pc);
            else n_pass++;
            n_checks++;
            if ({out_ctrl, out_illegal, out_is_ecall, out_is_ebreak, out_is_csr, out_csr_op} !==
                {e.ctrl, e.illegal, e.ecall, e.ebreak, e.csr, e.csr_op})
                $display("FAIL decode instr=%h got ctrl=%h il/ec/eb/csr=%b%b%b%b op=%0d required ctrl=%h il/ec/eb/csr=%b%b%b%b op=%0d",
                         e.instr, out_ctrl, out_illegal, out_is_ecall, out_is_ebreak, out_is_csr,
                         out_csr_op, e.ctrl, e.illegal, e.ecall, e.ebreak, e.csr, e.csr_op);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b required 0", in_ready);
        else n_pass++;
        n_checks++;
        if ({out_valid, occupancy} !== '0)
            $display("FAIL reset_state got out_valid=%b occupancy=%0d required 0/0", out_valid, occupancy);
        else n_pass++;
        n_checks++;
        if ({out_instr, out_pc, out_ctrl, out_illegal, out_is_ecall, out_is_ebreak, out_is_csr, out_csr_op} !== '0)
            $display("FAIL reset_fields got instr=%h pc=%h ctrl=%h required all 0", out_instr, out_pc, out_ctrl);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got %b required 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_addi();
        int fw, tot;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(ord(32'h00500093, 32'h100, c_addi));
        @(negedge clk);
        n_checks++;
        if ({out_valid, occupancy} !== {1'b0, CW'(1)})
            $display("FAIL addi_latency got out_valid=%b occupancy=%0d required 0/1", out_valid, occupancy);
        else n_pass++;
        collect(1, fw, tot);
        n_checks++;
        if (fw !== 1) $display("FAIL addi_out_valid_edge got wait=%0d required 1", fw);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int fw, tot;
        @(posedge clk); #1;
        out_ready = 1'b1;
        fork
            for (int i = 0; i < 6; i++)
                send(ord({12'(i + 1), 5'd0, 3'b000, 5'd1, 7'b0010011}, 32'h200 + 32'(4 * i), c_addi));
            collect(6, fw, tot);
        join
        n_checks++;
        if (tot - fw !== 5) $display("FAIL b2b_throughput got cycles=%0d required 5", tot - fw);
        else n_pass++;
    endtask

    task automatic run_vectors(input exp_t vec[$]);
        int fw, tot;
        @(posedge clk); #1;
        out_ready = 1'b1;
        fork
            foreach (vec[i]) send(vec[i]);
            collect(vec.size(), fw, tot);
        join
    endtask

    task automatic test_system();
        exp_t v[$];
        v.push_back(mk(32'h00000073, 32'h400, C_DEF, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0));
        v.push_back(mk(32'h00100073, 32'h404, C_DEF, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0));
        v.push_back(mk(32'h30002573, 32'h408, ctl(1,0,0,0,0,0,0,0,0,3'd0,ALU_PASS_B,MEM_WORD),
                       1'b0, 1'b0, 1'b0, 1'b1, 3'b010));
        v.push_back(mk(32'h30009073, 32'h40C, ctl(0,0,0,0,0,0,0,0,0,3'd0,ALU_PASS_B,MEM_WORD),
                       1'b0, 1'b0, 1'b0, 1'b1, 3'b001));
        v.push_back(ill(32'hFFFFFFFF, 32'h410));
        v.push_back(ill(32'h00004073, 32'h414));
        v.push_back(ill(32'h00200073, 32'h418));
        run_vectors(v);
    endtask

    task automatic test_decode_table();
        exp_t v[$];
        v.push_back(ord(32'h00812283, 32'h500, ctl(1,1,0,1,0,1,0,0,0,3'd0,ALU_ADD,MEM_WORD)));
        v.push_back(ord(32'h00014283, 32'h504, ctl(1,1,0,1,0,1,1,0,0,3'd0,ALU_ADD,MEM_BYTE)));
        v.push_back(ord(32'h00512223, 32'h508, ctl(0,1,0,0,1,0,0,0,0,3'd0,ALU_ADD,MEM_WORD)));
        v.push_back(ord(32'h00208463, 32'h50C, ctl(0,0,0,0,0,0,0,1,0,3'd0,ALU_SUB,MEM_WORD)));
        v.push_back(ord(32'h123450B7, 32'h510, ctl(1,1,0,0,0,0,0,0,0,3'd0,ALU_PASS_B,MEM_WORD)));
        v.push_back(ord(32'h010000EF, 32'h514, ctl(1,1,1,0,0,0,0,0,1,3'd0,ALU_ADD,MEM_WORD)));
        v.push_back(ord(32'h402081B3, 32'h518, ctl(1,0,0,0,0,0,0,0,0,3'd0,ALU_SUB,MEM_WORD)));
        v.push_back(ord(32'h4030D093, 32'h51C, ctl(1,1,0,0,0,0,0,0,0,3'd0,ALU_SRA,MEM_WORD)));
        v.push_back(ord(32'h00001297, 32'h520, ctl(1,1,1,0,0,0,0,0,0,3'd0,ALU_ADD,MEM_WORD)));
        v.push_back(ord(32'h0FF0000F, 32'h524, C_DEF));
        v.push_back(ill(32'h402091B3, 32'h528));
        v.push_back(ill(32'h00013283, 32'h52C));
        v.push_back(ill(32'h00500090, 32'h530));
        v.push_back(ill(32'h000090E7, 32'h534));
        v.push_back(ill(32'h02009093, 32'h538));
        run_vectors(v);
    endtask

    task automatic test_m_ext();
        exp_t v[$];
`ifdef RV_M_EXT_EN
        v.push_back(ord(32'h02208033, 32'h600, ctl(1,0,0,0,0,0,0,0,0,3'd0,ALU_MUL,MEM_WORD)));
`else
        v.push_back(ill(32'h02208033, 32'h600));
`endif
        run_vectors(v);
    endtask

    task automatic test_backpressure();
        int fw, tot;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++)
            send(ord({12'(i + 20), 5'd0, 3'b000, 5'd2, 7'b0010011}, 32'h700 + 32'(4 * i), c_addi));
        @(negedge clk);
        n_checks++;
        if ({in_ready, occupancy, out_valid} !== {1'b0, CW'(DEPTH), 1'b1})
            $display("FAIL full_state got in_ready=%b occupancy=%0d out_valid=%b required 0/%0d/1",
                     in_ready, occupancy, out_valid, DEPTH);
        else n_pass++;
        in_valid = 1'b1;
        in_instr = 32'h06300093;
        in_pc    = 32'h7FC;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (occupancy !== CW'(DEPTH))
            $display("FAIL full_refuse got occupancy=%0d required %0d", occupancy, DEPTH);
        else n_pass++;
        n_checks++;
        if ({out_valid, out_instr, out_pc} !== {1'b1, sb[0].instr, sb[0].pc})
            $display("FAIL stall_stable got v=%b instr=%h pc=%h required 1 instr=%h pc=%h",
                     out_valid, out_instr, out_pc, sb[0].instr, sb[0].pc);
        else n_pass++;
        @(posedge clk); #1;
        out_ready = 1'b1;
        collect(DEPTH + 1, fw, tot);
        n_checks++;
        if (tot !== DEPTH + 1) $display("FAIL drain_rate got cycles=%0d required %0d", tot, DEPTH + 1);
        else n_pass++;
    endtask

    task automatic test_flush();
        int fw, tot;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(ord({12'(i + 40), 5'd0, 3'b000, 5'd3, 7'b0010011}, 32'h800 + 32'(4 * i), c_addi));
        @(negedge clk);
        n_checks++;
        if ({occupancy, out_valid} !== {CW'(2), 1'b1})
            $display("FAIL flush_pre got occupancy=%0d out_valid=%b required 2/1", occupancy, out_valid);
        else n_pass++;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h00700113;
        in_pc     = 32'h8F0;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b required 0", in_ready);
        else n_pass++;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_valid, occupancy} !== '0)
            $display("FAIL flush_clear got out_valid=%b occupancy=%0d required 0/0", out_valid, occupancy);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out_valid, occupancy} !== '0)
            $display("FAIL flush_input_dropped got out_valid=%b occupancy=%0d required 0/0", out_valid, occupancy);
        else n_pass++;
        sb.delete();
        send(ord(32'h00900193, 32'h900, c_addi));
        collect(1, fw, tot);
    endtask

    task automatic test_reset_midstream();
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(ord({12'(i + 60), 5'd0, 3'b000, 5'd4, 7'b0010011}, 32'hA00 + 32'(4 * i), c_addi));
        @(negedge clk);
        n_checks++;
        if ({occupancy, out_valid} !== {CW'(3), 1'b1})
            $display("FAIL rst_pre got occupancy=%0d out_valid=%b required 3/1", occupancy, out_valid);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({occupancy, out_valid, in_ready} !== '0)
            $display("FAIL rst_async got occupancy=%0d out_valid=%b in_ready=%b required 0/0/0",
                     occupancy, out_valid, in_ready);
        else n_pass++;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, occupancy} !== {1'b1, CW'(0)})
            $display("FAIL rst_release got in_ready=%b occupancy=%0d required 1/0", in_ready, occupancy);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish required finish before 500000");
        $fatal(1, "simulation timeout");
    end

    initial begin
        c_addi = ctl(1,1,0,0,0,0,0,0,0,3'd0,ALU_ADD,MEM_WORD);
        test_reset();
        test_addi();
        test_back_to_back();
        test_system();
        test_decode_table();
        test_m_ext();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
